mem_pipe_ctrl: RTL and testbench
================================

Name: mem_pipe_ctrl

Overview:
- Parametrised successor to the team's single-port op/addr/data_in memory.
- Adds configurable width, depth and read latency, a valid/ready request handshake, byte-lane write enables, a pipelined read path with response valid, and a hardware clear sweep after reset.
- Sits behind the processor-side memory interface as the data store for the datapath.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
RD_LAT, 2, read latency in cycles from accepted read to rsp_valid; legal range 1..4.
CLR_VAL, 0, value written to every word during the post-reset clear sweep.

Ports:
clk  input  1  single clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_op  input  1  1 = write, 0 = read (same encoding as existing memory op).
req_addr  input  ADDR_W  word address.
req_data  input  DATA_W  write data.
req_be  input  DATA_W/8  byte-lane write enables; ignored on reads.
rsp_valid  output  1  read data valid, one-cycle pulse per read.
rsp_data  output  DATA_W  read data; holds last value when rsp_valid = 0.
init_done  output  1  high once the clear sweep has finished.

Behaviour:
- Reset (sync, active-high): req_ready = 0, rsp_valid = 0, rsp_data = 0, init_done = 0, read pipeline valid bits cleared, FSM goes to CLEAR with clr_addr = 0.
- FSM states:
  - CLEAR: writes CLR_VAL to mem[clr_addr] every cycle and increments clr_addr. When clr_addr = DEPTH-1 is written, go to READY next cycle. The sweep takes exactly DEPTH cycles; requests are not accepted.
  - READY: init_done = 1, req_ready = 1. A request is accepted when req_valid && req_ready.
- There is no stall state. Responses have no back-pressure, so req_ready stays 1 in READY every cycle.
- Write (accepted, req_op = 1): for each lane i with req_be[i] = 1, mem[req_addr][8i+7:8i] <= req_data lane i at that edge. Lanes with req_be = 0 are unchanged. req_be = 0 makes the write a no-op. No response is produced.
- Read (accepted, req_op = 0):
  - mem[req_addr] is sampled at the accept edge and enters an RD_LAT-deep pipeline.
  - rsp_valid rises exactly RD_LAT cycles after the accept edge, with rsp_data = sampled word.
  - Back-to-back reads produce back-to-back responses in order.
- Read-after-write: a write accepted in cycle N followed by a read of the same address in cycle N+1 returns the new data. Write-before-read ordering is guaranteed by sequential edges.
- Reset mid-operation: in-flight reads are discarded, so no rsp_valid pulse follows reset. Memory contents are re-cleared by a fresh sweep. init_done drops for the full DEPTH+1 cycles.
- Requests presented while req_ready = 0 are ignored and have no side effects.
- Address wrap: none. The full ADDR_W space is legal; clr_addr wraps only at sweep end, where the sweep terminates.

Decomposition:
- Package mem_pipe_pkg holds:
  - op encoding constants OP_READ = 0, OP_WRITE = 1;
  - state typedef enum {CLEAR, READY};
  - function byte_merge(old, new, be).
- One sub-module: mem_rd_pipe, a parametrised RD_LAT-stage valid/data shift register feeding rsp_valid/rsp_data.

Test Plan:
- Clear sweep: assert reset for 2 cycles with DEPTH = 16 → init_done and req_ready rise exactly 17 cycles after reset deasserts; reads of addr 0..15 all return 0.
- Full write/read: write addr 3 = 0xDEADBEEF, be = 4'hF, then read addr 3 → rsp_valid exactly RD_LAT = 2 cycles after accept, rsp_data = 0xDEADBEEF.
- Byte lanes: over 0xDEADBEEF at addr 3, write 0x11223344 with be = 4'b0101 → read returns 0xDE22BE44. A write with be = 0 leaves the word unchanged.
- Back-to-back reads: write addrs 0..3 with 0xA0..0xA3, then read them on 4 consecutive cycles → 4 consecutive rsp_valid pulses, data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Read-after-write: write addr 7 = 0x55 in cycle N, read addr 7 in cycle N+1 → rsp_data = 0x55.
- Reset mid-read: accept a read of addr 3, then assert reset the next cycle → no rsp_valid ever appears for that read; after the sweep completes, addr 3 reads 0. Repeat with RD_LAT = 1 and RD_LAT = 4.

Source files
------------

// File: rtl/mem_pipe_pkg.sv
// Shared definitions for the pipelined data store: op encoding, FSM states,
// and the byte-lane merge used by partial writes.
package mem_pipe_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  // Widest word byte_merge handles; callers zero-extend and truncate around it.
  localparam int unsigned MERGE_MAX_W = 1024;
  localparam int unsigned MERGE_BE_W  = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_BE_W-1:0]  be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// RD_LAT-stage valid/data shift register carrying sampled read words to the
// response port; the output data register holds its value between pulses.
module mem_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] stage_v;
  logic [DATA_W-1:0] stage_d [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_v <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) stage_d[k] <= '0;
    end else begin
      stage_v[0] <= in_valid;
      if (in_valid) stage_d[0] <= in_data;
      // Data only advances alongside a valid bit, so the last stage holds.
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        stage_v[k] <= stage_v[k-1];
        if (stage_v[k-1]) stage_d[k] <= stage_d[k-1];
      end
    end
  end

  assign out_valid = stage_v[RD_LAT-1];
  assign out_data  = stage_d[RD_LAT-1];

endmodule

// File: rtl/mem_pipe_ctrl.sv
// Parametrised single-port data store with valid/ready requests, byte-lane
// writes, a pipelined read path and a clear sweep after every reset.
module mem_pipe_ctrl
  import mem_pipe_pkg::*;
#(
  parameter int unsigned        DATA_W  = 32,
  parameter int unsigned        ADDR_W  = 4,
  parameter int unsigned        RD_LAT  = 2,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              accept;
  logic              rd_v;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;

  assign accept = req_valid && req_ready && (state == READY);

  always_comb begin
    wr_word = DATA_W'(byte_merge(MERGE_MAX_W'(mem[req_addr]),
                                 MERGE_MAX_W'(req_data),
                                 MERGE_BE_W'(req_be)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) state <= READY;
        end
        READY: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_addr] <= CLR_VAL;
      else if (accept && req_op == OP_WRITE)
        mem[req_addr] <= wr_word;
    end
  end

  // Accept-edge sample; the RD_LAT pipe stages follow it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v    <= 1'b0;
      rd_word <= '0;
    end else begin
      rd_v <= accept && (req_op == OP_READ);
      if (accept && req_op == OP_READ) rd_word <= mem[req_addr];
    end
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_v),
    .in_data   (rd_word),
    .out_valid (rsp_valid),
    .out_data  (rsp_data)
  );

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// Bench for mem_pipe_ctrl: three instances (RD_LAT 1, 2, 4) share one stimulus
// stream and are checked against a memory/read-log reference model.
module tb_mem_pipe_ctrl;

  localparam int unsigned SWEEP = 17;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_op;
  logic [3:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;

  logic [2:0]  rdy;
  logic [2:0]  idn;
  logic [2:0]  rv;
  logic [31:0] rdat [3];

  int          total;
  int          bad;
  int          cyc;
  int          m_cnt;
  logic        m_ready;
  logic [31:0] ref_mem [16];
  int          rd_cyc [$];
  logic [31:0] rd_dat [$];
  int          nx [3];
  logic [31:0] last [3];
  int          lat [3] = '{1, 2, 4};

  mem_pipe_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLR_VAL(32'h0)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .rsp_valid(rv[0]), .rsp_data(rdat[0]), .init_done(idn[0]));

  mem_pipe_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .CLR_VAL(32'h0)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .rsp_valid(rv[1]), .rsp_data(rdat[1]), .init_done(idn[1]));

  mem_pipe_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(4), .CLR_VAL(32'h0)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .rsp_valid(rv[2]), .rsp_data(rdat[2]), .init_done(idn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int j, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[lat%0d] got=%h exp=%h", tag, lat[j], got, exp);
    end
  endtask

  // One clock: drive, advance the model at the edge, then check all instances.
  task automatic step(input logic rst, input logic v, input logic op,
                      input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    logic exp_v;
    reset = rst; req_valid = v; req_op = op; req_addr = a; req_data = d; req_be = be;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_cnt = 0;
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      for (int j = 0; j < 3; j++) begin
        nx[j] = rd_cyc.size();
        last[j] = 32'h0;
      end
    end else begin
      if (m_ready && v) begin
        if (op) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
          rd_cyc.push_back(cyc);
          rd_dat.push_back(ref_mem[a]);
        end
      end
      if (m_cnt < SWEEP) m_cnt++;
      m_ready = (m_cnt == SWEEP);
    end
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("req_ready", j, {31'b0, rdy[j]}, {31'b0, m_ready});
      chk("init_done", j, {31'b0, idn[j]}, {31'b0, m_ready});
      exp_v = (nx[j] < rd_cyc.size()) && (rd_cyc[nx[j]] + lat[j] == cyc);
      chk("rsp_valid", j, {31'b0, rv[j]}, {31'b0, exp_v});
      if (exp_v) begin
        last[j] = rd_dat[nx[j]];
        nx[j]++;
      end
      chk("rsp_data", j, rdat[j], last[j]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b0, 1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; m_cnt = 0; m_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin nx[j] = 0; last[j] = 32'h0; end
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Reset for two cycles, then requests during the sweep must be ignored.
    step(1'b1, 1'b1, 1'b1, 4'h3, 32'hFFFF_FFFF, 4'hF);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom));
    idle(2);

    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(5);

    wr(4'h3, 32'hDEAD_BEEF, 4'hF);
    rd(4'h3);
    idle(5);
    wr(4'h3, 32'h1122_3344, 4'b0101);
    rd(4'h3);
    wr(4'h3, 32'h9999_9999, 4'h0);
    rd(4'h3);
    idle(5);

    for (int a = 0; a < 4; a++) wr(4'(a), 32'hA0 + 32'(a), 4'hF);
    for (int a = 0; a < 4; a++) rd(4'(a));
    idle(5);

    wr(4'h7, 32'h55, 4'hF);
    rd(4'h7);
    idle(5);

    // Read accepted, then reset the following cycle: the response must vanish.
    rd(4'h3);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    idle(SWEEP + 2);
    rd(4'h3);
    idle(6);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom), $urandom, 4'($urandom));
      else
        step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             4'($urandom), $urandom, 4'($urandom));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
